// File: rtl/midi_pkg.sv
// midi_pkg: MIDI message constants, byte type and note-message FSM states
package midi_pkg;
   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
   typedef logic [7:0] midi_byte_t;
   typedef enum logic [1:0] {IDLE, STAT, NOTE, VEL} note_msg_state_e;
   function automatic midi_byte_t midi_status(input logic [3:0] kind, input logic [3:0] ch);
      return {kind, ch};
   endfunction
endpackage

// File: rtl/btn_note_msg_if.sv
// btn_note_msg_if: valid/ready byte stream toward the UART transmitter
interface btn_note_msg_if;
   import midi_pkg::*;
   midi_byte_t tx_data;
   logic       tx_valid;
   logic       tx_ready;
   modport master(output tx_data, output tx_valid, input tx_ready);
   modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lowest_set_idx.sv
// lowest_set_idx: fixed-priority encoder, lowest set bit wins
module lowest_set_idx #(
   parameter int NUM_BTN = 4,
   parameter int IW      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
   input  logic [NUM_BTN-1:0] i_vec,
   output logic [IW-1:0]      o_idx,
   output logic               o_any
);
   always_comb begin
      o_idx = '0;
      o_any = |i_vec;
      for (int i = NUM_BTN - 1; i >= 0; i--)
         if (i_vec[i]) o_idx = IW'(i);
   end
endmodule

// File: rtl/btn_note_msg.sv
// btn_note_msg: latches button presses and emits 3-byte MIDI Note messages.
// Define BTN_NOTE_MSG_NOTE_OFF_EN to make each button toggle Note On / Note Off.
module btn_note_msg
   import midi_pkg::*;
#(
   parameter int NUM_BTN   = 4,
   parameter int MIDI_CH   = 0,
   parameter int BASE_NOTE = 60,
   parameter int VELOCITY  = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raised,
   btn_note_msg_if.master     tx,
   output logic               busy,
   output logic               dropped
);
   localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

   note_msg_state_e    r_state;
   logic [IW-1:0]      r_idx;
   logic [NUM_BTN-1:0] r_pend;
   midi_byte_t         r_data;
   logic               r_valid;
   logic               r_dropped;

   logic [IW-1:0]      w_idx;
   logic               w_any;
   logic               w_cap;
   logic [NUM_BTN-1:0] w_clr;
   logic               w_xfer;
   logic [7:0]         w_sum;
   midi_byte_t         w_note;
   logic               w_cap_off;
   logic               w_vel_off;

   lowest_set_idx #(.NUM_BTN(NUM_BTN), .IW(IW)) u_enc (
      .i_vec(r_pend),
      .o_idx(w_idx),
      .o_any(w_any)
   );

   assign w_cap  = (r_state == IDLE) && w_any;
   assign w_clr  = w_cap ? (NUM_BTN'(1) << w_idx) : '0;
   assign w_xfer = r_valid && tx.tx_ready;
   assign w_sum  = 8'(BASE_NOTE) + 8'(r_idx);
   assign w_note = w_sum & 8'h7F;

`ifdef BTN_NOTE_MSG_NOTE_OFF_EN
   logic [NUM_BTN-1:0] r_held;
   logic               r_off;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_held <= '0;
         r_off  <= 1'b0;
      end else begin
         if (w_cap) r_off <= r_held[w_idx];
         if (r_state == VEL && w_xfer) r_held[r_idx] <= ~r_held[r_idx];
      end
   end
   assign w_cap_off = r_held[w_idx];
   assign w_vel_off = r_off;
`else
   assign w_cap_off = 1'b0;
   assign w_vel_off = 1'b0;
`endif

   // a capture and a fresh raise of the same button leave the pend bit set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_pend    <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_pend    <= (r_pend & ~w_clr) | btn_raised;
         r_dropped <= |(btn_raised & r_pend & ~w_clr);
         case (r_state)
            IDLE: if (w_any) begin
               r_idx   <= w_idx;
               r_state <= STAT;
               r_valid <= 1'b1;
               r_data  <= midi_status(w_cap_off ? MIDI_NOTE_OFF : MIDI_NOTE_ON, 4'(MIDI_CH));
            end
            STAT: if (w_xfer) begin
               r_state <= NOTE;
               r_data  <= w_note;
            end
            NOTE: if (w_xfer) begin
               r_state <= VEL;
               r_data  <= w_vel_off ? 8'h00 : {1'b0, 7'(VELOCITY)};
            end
            default: if (w_xfer) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_data  <= '0;
            end
         endcase
      end
   end

   assign tx.tx_data  = r_data;
   assign tx.tx_valid = r_valid;
   assign busy        = (r_state != IDLE);
   assign dropped     = r_dropped;
endmodule

// File: tb/tb_btn_note_msg.sv
// tb_btn_note_msg: directed checks of btn_note_msg with default and wrapped parameters
module tb_btn_note_msg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn0 = '0;
   logic [3:0] btn1 = '0;
   logic       busy0, drop0, busy1, drop1;
   int         n_chk = 0;
   int         n_err = 0;
   int         n_drop0 = 0;

   btn_note_msg_if b0();
   btn_note_msg_if b1();

   btn_note_msg u0 (
      .clk(clk), .rst(rst), .btn_raised(btn0), .tx(b0), .busy(busy0), .dropped(drop0)
   );
   btn_note_msg #(.NUM_BTN(4), .MIDI_CH(15), .BASE_NOTE(126), .VELOCITY(100)) u1 (
      .clk(clk), .rst(rst), .btn_raised(btn1), .tx(b1), .busy(busy1), .dropped(drop1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (drop0) n_drop0 <= n_drop0 + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic press0(input logic [3:0] m);
      btn0 = m;
      tick();
      btn0 = '0;
   endtask

   task automatic expect_msg(input string tag, input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
      int k = 0;
      while (!b0.tx_valid && k < 20) begin
         tick();
         k++;
      end
      chk({tag, "_valid"}, 32'(b0.tx_valid), 32'd1);
      chk({tag, "_stat"}, 32'(b0.tx_data), 32'(s));
      tick();
      chk({tag, "_note"}, 32'(b0.tx_data), 32'(n));
      tick();
      chk({tag, "_vel"}, 32'(b0.tx_data), 32'(v));
      tick();
   endtask

   initial begin
      int cnt;
      int d0;
      logic ok;
      b0.tx_ready = 1'b1;
      b1.tx_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(b0.tx_valid), 32'd0);
      chk("rst_data", 32'(b0.tx_data), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_drop", 32'(drop0), 32'd0);
      rst = 1'b0;
      tick();

      // single press: first valid two edges after the pulse
      press0(4'b0001);
      chk("single_lat", 32'(b0.tx_valid), 32'd0);
      tick();
      chk("single_valid", 32'(b0.tx_valid), 32'd1);
      chk("single_stat", 32'(b0.tx_data), 32'h90);
      tick();
      chk("single_note", 32'(b0.tx_data), 32'h3C);
      tick();
      chk("single_vel", 32'(b0.tx_data), 32'h64);
      tick();
      chk("single_busy", 32'(busy0), 32'd0);
      chk("single_idle", 32'(b0.tx_valid), 32'd0);

      // simultaneous presses served lowest first with one idle gap
      d0 = n_drop0;
      press0(4'b1010);
      expect_msg("sim1", 8'h90, 8'h3D, 8'h64);
      chk("sim_gap", 32'(b0.tx_valid), 32'd0);
      tick();
      chk("sim_next", 32'(b0.tx_valid), 32'd1);
      expect_msg("sim2", 8'h90, 8'h3F, 8'h64);
      chk("sim_drop", 32'(n_drop0 - d0), 32'd0);
      tick();

      // backpressure in NOTE with two re-presses of button 0
      d0 = n_drop0;
      press0(4'b0001);
      tick();
      chk("bp_stat", 32'(b0.tx_data), 32'h90);
      tick();
      b0.tx_ready = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ok &= b0.tx_valid && (b0.tx_data == 8'h3C);
         if (i == 1 || i == 4) btn0 = 4'b0001;
         tick();
         btn0 = '0;
      end
      chk("bp_stable", 32'(ok), 32'd1);
      chk("bp_drop", 32'(n_drop0 - d0), 32'd1);
      b0.tx_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (b0.tx_valid) cnt++;
         tick();
      end
      chk("bp_bytes", 32'(cnt), 32'd5);
      chk("bp_busy", 32'(busy0), 32'd0);

      // channel 15 and note wrap on the second instance
      btn1 = 4'b1000;
      tick();
      btn1 = '0;
      tick();
      chk("wrap_stat", 32'(b1.tx_data), 32'h9F);
      tick();
      chk("wrap_note", 32'(b1.tx_data), 32'h01);
      tick();
      chk("wrap_vel", 32'(b1.tx_data), 32'h64);
      tick();

      // reset while in NOTE with button 2 still pending
      press0(4'b0101);
      tick();
      tick();
      chk("rm_note", 32'(b0.tx_data), 32'h3C);
      rst = 1'b1;
      tick();
      chk("rm_valid", 32'(b0.tx_valid), 32'd0);
      chk("rm_busy", 32'(busy0), 32'd0);
      rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ok |= b0.tx_valid;
      end
      chk("rm_quiet", 32'(ok), 32'd0);

      // repeated presses: toggle between On and Off when enabled
      press0(4'b0001);
      expect_msg("tog1", 8'h90, 8'h3C, 8'h64);
      press0(4'b0001);
`ifdef BTN_NOTE_MSG_NOTE_OFF_EN
      expect_msg("tog2", 8'h80, 8'h3C, 8'h00);
`else
      expect_msg("tog2", 8'h90, 8'h3C, 8'h64);
`endif
      press0(4'b0001);
      expect_msg("tog3", 8'h90, 8'h3C, 8'h64);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/btn_note_msg.md
# btn_note_msg

Consumes the one-cycle press pulses from the per-button debouncers and turns each press into a 3-byte MIDI Note message for the downstream UART transmitter. Presses are latched per button, so none are lost while a message is being sent. Pending presses are served in fixed priority order. Bytes leave over a valid/ready byte handshake.

## Interface
- `NUM_BTN`, 4: number of buttons, 1..16.
- `MIDI_CH`, 0: MIDI channel, 0..15. Forms the low nibble of the status byte.
- `BASE_NOTE`, 60: note number for button 0. Button i sends `BASE_NOTE + i`.
- `VELOCITY`, 100: Note On velocity, 1..127.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raised`  in  NUM_BTN  one-cycle press pulses, one bit per debounced button.
- `tx_data`  out  8  MIDI byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid. Held until accepted.
- `tx_ready`  in  1  UART accepts the byte. A transfer happens on a cycle with `tx_valid && tx_ready`.
- `busy`  out  1  a message is in progress (FSM state is not IDLE).
- `dropped`  out  1  one-cycle pulse: a press arrived while that button's pending bit was already set and nothing freed it.

## Operation
- **Pending register** `pend[NUM_BTN-1:0]`:
  - `btn_raised[i]` sets `pend[i]`.
  - The FSM clears `pend[i]` when it captures button i.
  - Capture and a new raise for the same i in the same cycle: `pend[i]` stays 1. The new press is queued, not dropped.
  - Raise while `pend[i]=1` and button i is not being captured: `dropped` pulses.
- **FSM states:** IDLE, STAT, NOTE, VEL.
  - IDLE: when `pend != 0`, capture the lowest set index into `idx`, clear that pend bit, go to STAT.
  - STAT: drive `{4'h9, MIDI_CH[3:0]}`. On transfer go to NOTE.
  - NOTE: drive `{1'b0, (BASE_NOTE + idx) & 7'h7F}`. The sum is computed 8 bits wide and wraps modulo 128. On transfer go to VEL.
  - VEL: drive `{1'b0, VELOCITY[6:0]}`. On transfer go to IDLE.
- `tx_valid = 1` in STAT, NOTE and VEL; 0 in IDLE.
- `tx_data` is stable while `tx_valid=1` and `tx_ready=0`. `tx_data` is 0 in IDLE.
- No running status: every message carries its status byte.

## Timing
- **Reset values:** `tx_valid=0`, `tx_data=0`, `busy=0`, `dropped=0`, `pend=0`, state IDLE.
- **Reset mid-message:** the message is aborted. The next cycle shows `tx_valid=0`. Pending presses are discarded.
- **Latency:** `btn_raised` sampled at edge t → `pend` set after t → capture at t+1 → `tx_valid=1` after edge t+1.
- **Throughput with `tx_ready` tied high:**
  - One byte per cycle inside a message.
  - One IDLE cycle between messages, so 4 cycles per message.
- **Arbitration:** simultaneous presses are served lowest index first, one message each, back to back.
- **Stall:** `tx_ready` may be low arbitrarily long. The block holds state and keeps latching presses.

## Configuration
- `BTN_NOTE_MSG_NOTE_OFF_EN` defined:
  - Each button keeps a toggle bit `held[i]`, reset to 0.
  - Capture with `held[idx]=0` sends Note On as above.
  - Capture with `held[idx]=1` sends Note Off: status `{4'h8, MIDI_CH}`, velocity `8'h00`.
  - `held[idx]` flips when the VEL byte transfers.
  - A reset mid-message leaves all `held` bits at 0.
- Macro not defined: no `held` state. Every press sends Note On.

## Structure
- **Package `midi_pkg`:**
  - `MIDI_NOTE_ON = 4'h9`, `MIDI_NOTE_OFF = 4'h8`.
  - `midi_byte_t` (8-bit typedef).
  - FSM enum `note_msg_state_e`.
  - The UART transmitter reuses these.
- **Sub-module `lowest_set_idx`:**
  - Parameterized fixed-priority encoder, purely combinational.
  - Inputs: `NUM_BTN`-bit vector. Outputs: `$clog2(NUM_BTN)`-bit index and an `any` flag.
- All else stays in `btn_note_msg`.

## Test plan
- **Single press.** Defaults, `tx_ready=1`, pulse `btn_raised=4'b0001` for one cycle → bytes `0x90, 0x3C, 0x64` on consecutive cycles. First `tx_valid` two edges after the pulse. Then `busy=0`.
- **Simultaneous presses.** Pulse `btn_raised=4'b1010` → message for note `0x3D` (button 1), then one IDLE cycle, then message for note `0x3F` (button 3). No `dropped`.
- **Backpressure.** Hold `tx_ready=0` for 10 cycles during NOTE → `tx_data=0x3C` stable with `tx_valid=1` throughout. Pulse button 0 twice during the stall:
  - the first re-press is queued;
  - the second pulses `dropped`;
  - exactly two messages go out in total.
- **Wrap and channel.** `MIDI_CH=15`, `BASE_NOTE=126`, press button 3 → `0x9F, 0x01, 0x64`.
- **Reset mid-message.** Assert `rst` while in NOTE with button 2 pending → `tx_valid=0` next cycle. No further bytes after reset is released.
- **Note Off toggle.** With `BTN_NOTE_MSG_NOTE_OFF_EN` defined, press button 0 twice → `0x90, 0x3C, 0x64` then `0x80, 0x3C, 0x00`. A third press sends Note On again.
